// File: rtl/alu_issue_ctrl_pkg.sv
// alu_defs: shared ALU mode, ALUOp, R-type opcode and FSM encodings.
// Used by the ALU, alu_mode_decode and alu_issue_ctrl.
package alu_defs;

  typedef enum logic [3:0] {
    MODE_AND   = 4'b0000,
    MODE_OR    = 4'b0001,
    MODE_ADD   = 4'b0010,
    MODE_LSL   = 4'b0011,
    MODE_LSR   = 4'b0100,
    MODE_SUB   = 4'b0110,
    MODE_PASSB = 4'b0111,
    MODE_NOR   = 4'b1100
  } alu_mode_e;

  typedef enum logic [1:0] {
    ALUOP_LDST  = 2'b00,
    ALUOP_CBZ   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;
  localparam logic [10:0] OPC_LSL = 11'b11010011011;
  localparam logic [10:0] OPC_LSR = 11'b11010011010;
  localparam logic [10:0] OPC_NOR = 11'b11101010001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response plus ALU-side bundle for alu_issue_ctrl.
// slave: the issue controller; master: requester and ALU.
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 64
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_aluop;
  logic [10:0]      req_opcode;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [WIDTH-1:0] alu_r1;
  logic [WIDTH-1:0] alu_r2;
  logic [3:0]       alu_mode;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;

  modport slave (
    input  req_valid, req_aluop, req_opcode,
    input  req_a, req_b,
    input  alu_out, alu_zero, rsp_ready,
    output req_ready, alu_r1, alu_r2, alu_mode,
    output rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport master (
    output req_valid, req_aluop, req_opcode,
    output req_a, req_b,
    output alu_out, alu_zero, rsp_ready,
    input  req_ready, alu_r1, alu_r2, alu_mode,
    input  rsp_valid, rsp_result, rsp_zero, rsp_err
  );

endinterface

// File: rtl/alu_issue_ctrl_mode_decode.sv
// alu_mode_decode: (aluop, opcode) -> ALU mode, err on unsupported.
// Ports: i_aluop, i_opcode in; o_mode, o_err out. Purely combinational.
import alu_defs::*;

module alu_mode_decode (
  input  logic [1:0]  i_aluop,
  input  logic [10:0] i_opcode,
  output alu_mode_e   o_mode,
  output logic        o_err
);

  logic w_rt;
  assign w_rt = (i_aluop == ALUOP_RTYPE);

  always_comb begin
    o_mode = MODE_AND;
    o_err  = 1'b0;
    unique case (1'b1)
      (i_aluop == ALUOP_LDST):         o_mode = MODE_ADD;
      (i_aluop == ALUOP_CBZ):          o_mode = MODE_PASSB;
      (w_rt && i_opcode == OPC_ADD):   o_mode = MODE_ADD;
      (w_rt && i_opcode == OPC_SUB):   o_mode = MODE_SUB;
      (w_rt && i_opcode == OPC_AND):   o_mode = MODE_AND;
      (w_rt && i_opcode == OPC_ORR):   o_mode = MODE_OR;
      (w_rt && i_opcode == OPC_LSL):   o_mode = MODE_LSL;
      (w_rt && i_opcode == OPC_LSR):   o_mode = MODE_LSR;
      (w_rt && i_opcode == OPC_NOR):   o_mode = MODE_NOR;
      default:                         o_err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: registers ALU operands/mode, waits SETTLE cycles,
// captures Out/Zero and returns it. Ports: clk, reset_n, bus (slave).
import alu_defs::*;

module alu_issue_ctrl #(
  parameter int WIDTH  = 64,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  alu_issue_ctrl_if.slave bus
);

  state_e           r_state;
  state_e           w_next;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_r1;
  logic [WIDTH-1:0] r_r2;
  alu_mode_e        r_mode;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_err;

  alu_mode_e        w_mode;
  logic             w_err;
  logic             w_req_ready;
  logic             w_rsp_valid;
  logic             w_fire;
  logic             w_done;

  alu_mode_decode u_dec (
    .i_aluop  (bus.req_aluop),
    .i_opcode (bus.req_opcode),
    .o_mode   (w_mode),
    .o_err    (w_err)
  );

  assign w_fire = bus.req_valid && w_req_ready;
  assign w_done = (r_state == ST_WAIT) && (r_cnt == 4'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_fire)
                 w_next = w_err ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd0)
                 w_next = ST_RESP;
      ST_RESP: if (bus.rsp_ready)
                 w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_req_ready = (r_state == ST_IDLE);
    w_rsp_valid = (r_state == ST_RESP);
  end

  // Error requests leave the ALU inputs untouched so the
  // previous operation stays visible on the ALU.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= 4'd0;
      r_r1     <= '0;
      r_r2     <= '0;
      r_mode   <= MODE_AND;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_fire) begin
        if (w_err) begin
          r_err    <= 1'b1;
          r_result <= '0;
          r_zero   <= 1'b0;
        end else begin
          r_r1   <= bus.req_a;
          r_r2   <= bus.req_b;
          r_mode <= w_mode;
          r_cnt  <= 4'(SETTLE - 1);
        end
      end
      if (w_done) begin
        r_result <= bus.alu_out;
        r_zero   <= bus.alu_zero;
        r_err    <= 1'b0;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.alu_r1     = r_r1;
  assign bus.alu_r2     = r_r2;
  assign bus.alu_mode   = r_mode;
  assign bus.rsp_result = r_result;
  assign bus.rsp_zero   = r_zero;
  assign bus.rsp_err    = r_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU.
// Checks reset, decode, latency, backpressure, errors, mid-op reset.
module tb_alu_issue_ctrl;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_fail;
  int   lat;

  alu_issue_ctrl_if #(.WIDTH(64)) bus ();

  alu_issue_ctrl #(
    .WIDTH  (64),
    .SETTLE (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.alu_out = '0;
    case (bus.alu_mode)
      4'h0: bus.alu_out = bus.alu_r1 & bus.alu_r2;
      4'h1: bus.alu_out = bus.alu_r1 | bus.alu_r2;
      4'h2: bus.alu_out = bus.alu_r1 + bus.alu_r2;
      4'h3: bus.alu_out = bus.alu_r1 << bus.alu_r2;
      4'h4: bus.alu_out = bus.alu_r1 >> bus.alu_r2;
      4'h6: bus.alu_out = bus.alu_r1 - bus.alu_r2;
      4'h7: bus.alu_out = bus.alu_r2;
      4'hC: bus.alu_out = ~(bus.alu_r1 | bus.alu_r2);
      default: bus.alu_out = '0;
    endcase
  end
  assign bus.alu_zero = (bus.alu_out == 64'd0);

  typedef struct {
    logic [1:0]  op;
    logic [10:0] opc;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  mode;
    logic [63:0] res;
    logic        z;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_rsp(output int l);
    l = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      l++;
      if (bus.rsp_valid) break;
    end
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic [10:0] opc,
                       input logic [63:0] a,
                       input logic [63:0] b,
                       output int l);
    int n;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", 0, 1);
    bus.req_aluop  = op;
    bus.req_opcode = opc;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_rsp(l);
  endtask

  task automatic rsp_done();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    chk("rsp_drop", bus.rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    n_chk  = 0;
    n_fail = 0;
    vt[0] = '{2'b10, 11'b10001011000, 64'd5, 64'd7,
              4'h2, 64'd12, 1'b0};
    vt[1] = '{2'b10, 11'b11001011000, 64'd9, 64'd9,
              4'h6, 64'd0, 1'b1};
    vt[2] = '{2'b01, 11'd0, 64'h55, 64'd0,
              4'h7, 64'd0, 1'b1};
    vt[3] = '{2'b01, 11'd0, 64'h55, 64'h10,
              4'h7, 64'h10, 1'b0};
    vt[4] = '{2'b10, 11'b10001010000, 64'hF0F0, 64'hFF00,
              4'h0, 64'hF000, 1'b0};
    vt[5] = '{2'b10, 11'b10101010000, 64'hF0, 64'h0F,
              4'h1, 64'hFF, 1'b0};
    vt[6] = '{2'b10, 11'b11010011011, 64'd1, 64'd4,
              4'h3, 64'd16, 1'b0};
    vt[7] = '{2'b10, 11'b11010011010, 64'h100, 64'd4,
              4'h4, 64'h10, 1'b0};
    vt[8] = '{2'b10, 11'b11101010001, 64'd0, 64'd0,
              4'hC, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vt[9] = '{2'b00, 11'b11111111111, 64'd100, 64'd20,
              4'h2, 64'd120, 1'b0};

    reset_n        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_aluop  = 2'b00;
    bus.req_opcode = 11'd0;
    bus.req_a      = 64'd0;
    bus.req_b      = 64'd0;
    bus.rsp_ready  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_result", bus.rsp_result, 0);
    chk("rst_zero", bus.rsp_zero, 0);
    chk("rst_err", bus.rsp_err, 0);
    chk("rst_r1", bus.alu_r1, 0);
    chk("rst_r2", bus.alu_r2, 0);
    chk("rst_mode", bus.alu_mode, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      // vector 3 holds rsp_ready high before rsp_valid rises
      bus.rsp_ready = (i == 3);
      issue(vt[i].op, vt[i].opc, vt[i].a, vt[i].b, lat);
      chk($sformatf("v%0d_lat", i), lat, 3);
      chk($sformatf("v%0d_mode", i), bus.alu_mode, vt[i].mode);
      chk($sformatf("v%0d_res", i), bus.rsp_result, vt[i].res);
      chk($sformatf("v%0d_zero", i), bus.rsp_zero, vt[i].z);
      chk($sformatf("v%0d_err", i), bus.rsp_err, 0);
      rsp_done();
    end

    issue(2'b10, 11'b11111111111, 64'd1, 64'd1, lat);
    chk("e1_lat", lat, 1);
    chk("e1_err", bus.rsp_err, 1);
    chk("e1_res", bus.rsp_result, 0);
    chk("e1_zero", bus.rsp_zero, 0);
    chk("e1_mode", bus.alu_mode, 4'h2);
    chk("e1_r1", bus.alu_r1, 64'd100);
    rsp_done();
    issue(2'b11, 11'b10001011000, 64'd3, 64'd3, lat);
    chk("e2_lat", lat, 1);
    chk("e2_err", bus.rsp_err, 1);
    chk("e2_mode", bus.alu_mode, 4'h2);
    rsp_done();

    issue(2'b10, 11'b10001011000, 64'd1, 64'd2, lat);
    chk("bp_lat", lat, 3);
    chk("bp_res", bus.rsp_result, 64'd3);
    bus.req_aluop  = 2'b10;
    bus.req_opcode = 11'b10001011000;
    bus.req_a      = 64'd100;
    bus.req_b      = 64'd200;
    bus.req_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_hold", bus.rsp_result, 64'd3);
      chk("bp_ready", bus.req_ready, 0);
      chk("bp_r1", bus.alu_r1, 64'd1);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    chk("bp_idle_valid", bus.rsp_valid, 0);
    chk("bp_idle_ready", bus.req_ready, 1);
    chk("bp_idle_r1", bus.alu_r1, 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    chk("bp2_ready", bus.req_ready, 0);
    chk("bp2_r1", bus.alu_r1, 64'd100);
    wait_rsp(lat);
    chk("bp2_lat", lat, 3);
    chk("bp2_res", bus.rsp_result, 64'd300);
    chk("bp2_err", bus.rsp_err, 0);
    rsp_done();

    bus.req_aluop  = 2'b10;
    bus.req_opcode = 11'b10001011000;
    bus.req_a      = 64'd7;
    bus.req_b      = 64'd8;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("ar_wait_ready", bus.req_ready, 0);
    reset_n = 1'b0;
    #1;
    chk("ar_r1", bus.alu_r1, 0);
    chk("ar_r2", bus.alu_r2, 0);
    chk("ar_mode", bus.alu_mode, 0);
    chk("ar_ready", bus.req_ready, 1);
    chk("ar_valid", bus.rsp_valid, 0);
    chk("ar_res", bus.rsp_result, 0);
    @(negedge clk);
    reset_n = 1'b1;
    busy = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid) busy++;
    end
    chk("ar_no_rsp", busy, 0);
    issue(2'b10, 11'b11001011000, 64'd10, 64'd3, lat);
    chk("ar_new_lat", lat, 3);
    chk("ar_new_res", bus.rsp_result, 64'd7);
    chk("ar_new_mode", bus.alu_mode, 4'h6);
    rsp_done();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Driving end of the ALU operand/Mode interface in the ARMv8 datapath: decodes the ARMv8 11-bit opcode plus ALUOp into the 4-bit ALU Mode and issues operands.
- Waits a fixed settle latency, captures the ALU Out/Zero, and returns the result to the requester over a valid/ready handshake.
- Replaces the combinational ALU-control path, so the multi-cycle datapath can tolerate the ALU's propagation delay.

Parameters:
- WIDTH, 64, operand/result width
- SETTLE, 2, cycles between driving ALU inputs and capturing Out/Zero (legal range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_aluop  in  2  00 load/store, 01 CBZ, 10 R-type, 11 reserved
- req_opcode  in  11  instruction[31:21]
- req_a  in  WIDTH  operand 1 (Rn)
- req_b  in  WIDTH  operand 2 (Rm / immediate / Rt)
- alu_r1  out  WIDTH  to ALU R1
- alu_r2  out  WIDTH  to ALU R2
- alu_mode  out  4  to ALU Mode
- alu_out  in  WIDTH  from ALU Out
- alu_zero  in  1  from ALU Zero
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  WIDTH  captured ALU Out
- rsp_zero  out  1  captured ALU Zero
- rsp_err  out  1  unsupported aluop/opcode

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - req_ready=1, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0.
  - alu_r1=0, alu_r2=0, alu_mode=AND (0000).
- Mode encodings: AND 0000, OR 0001, ADD 0010, LSL 0011, LSR 0100, SUB 0110, PassB 0111, NOR 1100.
- Decode:
  - aluop 00 -> ADD.
  - aluop 01 -> PassB.
  - aluop 10 decodes the opcode: 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 OR, 11010011011 LSL, 11010011010 LSR, 11101010001 NOR.
  - Any other R-type opcode, or aluop 11 -> err.
- FSM IDLE -> WAIT -> RESP -> IDLE:
  - IDLE: req_ready=1. On req_valid&&req_ready:
    - register a, b and the decoded mode into alu_r1/alu_r2/alu_mode.
    - load the counter with SETTLE-1 and go to WAIT.
    - If err: skip WAIT and go straight to RESP with rsp_err=1, rsp_result=0, rsp_zero=0. ALU outputs stay unchanged.
  - WAIT: req_ready=0. Decrement the counter; when it is 0, capture alu_out→rsp_result and alu_zero→rsp_zero, set rsp_valid=1, rsp_err=0, go to RESP.
  - RESP: rsp_valid=1 and the result is stable. On rsp_ready go to IDLE with rsp_valid=0. No new request is accepted in the same cycle (req_ready goes high the cycle after).
- Latency:
  - Valid request: handshake edge to rsp_valid = SETTLE+1 cycles (3 at default).
  - Error request: 1 cycle.
- Throughput: one outstanding operation; back-to-back minimum period is SETTLE+2 cycles.
- ALU inputs hold their last values after completion (no return to 0), so ALU Out is stable for debug.
- A held rsp_ready=1 before rsp_valid rises completes the handshake in the first RESP cycle.
- req_a/req_b changing during WAIT has no effect (inputs are registered).
- Reset mid-operation aborts: any response is discarded and all outputs take their reset values immediately.
- Shift amount is the full req_b. The ALU is responsible for shift semantics; this block only passes it through.

Decomposition:
- Shared package alu_defs holds:
  - Mode constants (AND, OR, ADD, SUB, NOR, LSL, LSR, PassB).
  - ALUOp constants.
  - R-type opcode constants.
  - FSM state encoding.
- These replace the per-file defines, so the ALU and this block share one definition.
- One sub-module: alu_mode_decode, combinational (aluop, opcode) -> (mode, err). It is reused by the single-cycle control path.

Test Plan:
- aluop=10, opcode=10001011000, a=5, b=7, SETTLE=2 -> alu_mode=0010; rsp_valid 3 cycles after handshake; rsp_result=12, rsp_zero=0, rsp_err=0.
- aluop=10, opcode=11001011000, a=9, b=9 -> alu_mode=0110, rsp_result=0, rsp_zero=1.
- aluop=01 (CBZ), b=0 -> alu_mode=0111, rsp_zero=1; then b=0x10 -> rsp_result=0x10, rsp_zero=0.
- aluop=10, opcode=11111111111 -> rsp_valid after 1 cycle, rsp_err=1, rsp_result=0, alu_mode unchanged.
- rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_result stable, req_ready=0 throughout, a second req_valid is not accepted; rsp_ready=1 -> IDLE next cycle, then the second request is accepted.
- reset_n pulsed low during WAIT -> outputs take their reset values asynchronously; no rsp_valid for the aborted op; a new request after release completes normally.
